instr_prefetch: RTL
===================

INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 The block SHALL have parameter ADDR_W, default `ADDR_W, meaning instruction address width.
REQ-002 The block SHALL have parameter WORD_W, default `WORD_W, meaning instruction word width.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning buffer entries; legal values are powers of 2, minimum 2.
REQ-004 The block SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset: clk  in  1  clock, all state changes on its rising edge.
REQ-006 areset  in  1  asynchronous active-high reset.
REQ-007 o_instr_req_addr  out  ADDR_W  fetch address to instruction_memory.
REQ-008 o_instr_req_en  out  1  fetch request strobe.
REQ-009 i_instr_res_data  in  WORD_W  instruction word, valid exactly 1 cycle after the request.
REQ-010 i_redirect_en  in  1  branch/jump redirect strobe from the pipeline.
REQ-011 i_redirect_addr  in  ADDR_W  redirect target.
REQ-012 o_instr_valid  out  1  head entry valid toward decode.
REQ-013 o_instr_data  out  WORD_W  head instruction word.
REQ-014 o_instr_pc  out  ADDR_W  address of the head instruction.
REQ-015 i_instr_ready  in  1  decode accepts the head entry.

Function
REQ-016 The block SHALL hold a fetch PC, a DEPTH-entry FIFO of {word, pc}, an occupancy count (0..DEPTH), and an in-flight flag plus in-flight PC.
REQ-017 o_instr_req_addr SHALL equal the fetch PC at all times.
REQ-018 o_instr_req_en SHALL be combinationally 1 iff count + in-flight < DEPTH and i_redirect_en = 0; the pop in the same cycle is not credited.
REQ-019 On a cycle with o_instr_req_en = 1, the block SHALL set in-flight = 1, capture in-flight PC = fetch PC, and advance fetch PC by 4, wrapping modulo 2^ADDR_W.
REQ-020 On a cycle with o_instr_req_en = 0 and no redirect, in-flight SHALL clear and fetch PC SHALL hold.
REQ-021 When in-flight = 1, the block SHALL push {i_instr_res_data, in-flight PC} into the FIFO tail that cycle.
REQ-022 o_instr_valid SHALL be count != 0, and o_instr_data/o_instr_pc SHALL show the head entry; they are 0 when the FIFO is empty.
REQ-023 The block SHALL pop the head when o_instr_valid = 1 and i_instr_ready = 1.
REQ-024 On a simultaneous push and pop, count SHALL be unchanged and FIFO order SHALL be preserved; the full-plus-push case is unreachable by REQ-018.
REQ-025 On i_redirect_en = 1, the block SHALL, at the clock edge:
- flush the FIFO (count = 0);
- squash any in-flight response (no push that cycle, in-flight = 0);
- set fetch PC = i_redirect_addr;
- ignore any pop or push.
REQ-026 In the cycle after a redirect, the block SHALL issue a request to i_redirect_addr, with o_instr_valid rising 2 cycles after the redirect edge.
REQ-027 Back-to-back redirects SHALL each override the previous one; only the last target is fetched.
REQ-028 Steady-state throughput SHALL be 1 instruction/cycle with i_instr_ready held at 1, and fetch-to-valid latency SHALL be 1 cycle after the response.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-030 While areset = 1, asynchronously:
- fetch PC = RESET_PC;
- count, pointers and in-flight = 0;
- o_instr_valid = 0, o_instr_data = 0, o_instr_pc = 0;
- o_instr_req_en = 0.
REQ-031 After areset is released, the first request SHALL issue RESET_PC in the first cycle.
REQ-032 Reset asserted mid-operation SHALL discard all buffered and in-flight instructions, and any response arriving after release SHALL NOT be pushed.

Verification
REQ-033 Reset release, i_instr_ready = 1, memory returning word = addr ^ 32'hA5A5_0000 -> requests 0,4,8,…; o_instr_valid from cycle 2; pc/data sequence in order, no gaps.
REQ-034 i_instr_ready = 0 from reset -> exactly 4 requests (0..12), o_instr_req_en = 0 thereafter, count = 4; release ready -> entries 0,4,8,12 drain 1/cycle and fetching resumes at 16.
REQ-035 Redirect to 0x100 while the FIFO holds 3 entries and a request is in flight -> next cycle o_instr_valid = 0; request 0x100 issued; the squashed word is never output; first valid pc = 0x100.
REQ-036 Redirect in two consecutive cycles (0x200, then 0x300) -> 0x200 is never requested; the first valid pc is 0x300.
REQ-037 Fetch PC at 2^ADDR_W - 4 -> next request address is 0.
REQ-038 areset pulsed for 1 cycle mid-stream with a full FIFO -> outputs drop to 0 immediately; after release fetching restarts at RESET_PC; no stale word appears.

Source files
------------

// File: rtl/instr_prefetch.sv
// instr_prefetch: instruction prefetch buffer with a 1-cycle memory interface.
// It keeps a DEPTH-entry {word, pc} FIFO toward decode and handles redirect flushes.
`timescale 1ns/1ps
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif

`default_nettype none

module instr_prefetch #(
    parameter int                ADDR_W   = `ADDR_W,
    parameter int                WORD_W   = `WORD_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              areset,
    output logic [ADDR_W-1:0] o_instr_req_addr,
    output logic              o_instr_req_en,
    input  logic [WORD_W-1:0] i_instr_res_data,
    input  logic              i_redirect_en,
    input  logic [ADDR_W-1:0] i_redirect_addr,
    output logic              o_instr_valid,
    output logic [WORD_W-1:0] o_instr_data,
    output logic [ADDR_W-1:0] o_instr_pc,
    input  logic              i_instr_ready
);

    localparam int              PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [WORD_W-1:0] buf_word_q [DEPTH];
    logic [ADDR_W-1:0] buf_pc_q   [DEPTH];

    logic [CNT_W:0]    occupancy;
    logic              req_en;
    logic              push;
    logic              pop;

    // The pop in the current cycle is deliberately not credited toward free space.
    assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign req_en    = !areset && !i_redirect_en && (occupancy < DEPTH_C);
    assign push      = inflight_q && !i_redirect_en;
    assign pop       = o_instr_valid && i_instr_ready && !i_redirect_en;

    assign o_instr_req_addr = fetch_pc_q;
    assign o_instr_req_en   = req_en;
    assign o_instr_valid    = (count_q != '0);
    assign o_instr_data     = o_instr_valid ? buf_word_q[rd_ptr_q] : '0;
    assign o_instr_pc       = o_instr_valid ? buf_pc_q[rd_ptr_q]   : '0;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = 1'b0;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        if (i_redirect_en) begin
            fetch_pc_d = i_redirect_addr;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (req_en) begin
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + ADDR_W'(4);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Storage needs no reset: reads are masked whenever the count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_word_q[wr_ptr_q] <= i_instr_res_data;
            buf_pc_q[wr_ptr_q]   <= inflight_pc_q;
        end
    end

endmodule

`default_nettype wire
